wifi_rx_depuncturer: RTL and testbench

Receive-side counterpart of the TX puncturer buffer. Accepts the received soft-bit stream one symbol per cycle into an internal FIFO. Re-inserts erasures at the positions the transmitter punctured (802.11a rates 1/2, 2/3, 3/4). Emits (A,B) soft-bit pairs with erase flags to the Viterbi decoder under ready/valid backpressure.

---
 rtl/wifi_rx_pkg.sv | 48 ++++
 rtl/wifi_rx_depuncturer_fifo.sv | 64 ++++++
 rtl/wifi_rx_depuncturer.sv | 172 +++++++++++++++++
 tb/tb_wifi_rx_depuncturer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wifi_rx_pkg.sv
// Shared definitions for the receive depuncturer: rate codes, FSM states,
// erasure value and the puncture-pattern lookup.
package wifi_rx_pkg;

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  // Soft value substituted for a punctured bit.
  localparam int unsigned ERASE_VAL = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_CAP_A,
    ST_RD_B,
    ST_CAP_B,
    ST_OUT
  } state_e;

  // Returns {keep_a, keep_b} for a rate and phase; reserved rate acts as 1/2.
  function automatic logic [1:0] punct_keep(input logic [1:0] rate,
                                            input logic [1:0] phase);
    logic [1:0] keep;
    keep = 2'b11;
    case (rate)
      RATE_2_3: if (phase == 2'd1) keep = 2'b10;
      RATE_3_4: begin
        if (phase == 2'd1)      keep = 2'b10;
        else if (phase == 2'd2) keep = 2'b01;
      end
      default:  keep = 2'b11;
    endcase
    return keep;
  endfunction

  // Number of pairs in one puncture period.
  function automatic logic [1:0] punct_period(input logic [1:0] rate);
    logic [1:0] per;
    case (rate)
      RATE_2_3: per = 2'd2;
      RATE_3_4: per = 2'd3;
      default:  per = 2'd1;
    endcase
    return per;
  endfunction

endpackage

// File: rtl/wifi_rx_depuncturer_fifo.sv
// Soft-symbol FIFO with registered read and synchronous flush.
// Ports: clk, reset (async active-low), flush_i, push_i/wdata_i (write),
// pop_i (read, data on rdata_o next cycle), full_o, empty_o.
// Depth MEM must equal 2**AD so the pointers wrap naturally.
module wifi_rx_depuncturer_fifo #(
  parameter int unsigned SW  = 3,
  parameter int unsigned AD  = 6,
  parameter int unsigned MEM = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [SW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [SW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [SW-1:0] mem_q [MEM];
  logic [AD-1:0] wr_ptr_q, rd_ptr_q;
  logic [AD:0]   count_q;
  logic [SW-1:0] rdata_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AD+1)'(MEM));
  assign empty_o = (count_q == '0);
  assign rdata_o = rdata_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // RAM array: no reset, a write during flush lands at address 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[flush_i ? '0 : wr_ptr_q] <= wdata_i;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= do_push ? AD'(1) : '0;
      count_q  <= do_push ? (AD+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AD'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AD'(1);
        rdata_q  <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AD+1)'(1);
        2'b01:   count_q <= count_q - (AD+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wifi_rx_depuncturer.sv
// Receive depuncturer: buffers soft symbols and emits (A,B) pairs with
// erasures re-inserted for 802.11a rates 1/2, 2/3 and 3/4.
// Ports: clk, reset (async active-low), start/rate (frame setup),
// valid_in/data_in/in_ready (symbol input), out_ready/valid_out/data_a/
// data_b/erase_a/erase_b (pair output).
// Optional macro WIFI_RX_DEPUNCT_COUNT_EN adds pair_count[15:0], a saturating
// count of output handshakes since reset or start.
module wifi_rx_depuncturer
  import wifi_rx_pkg::*;
#(
  parameter int unsigned SW  = 3,
  parameter int unsigned AD  = 6,
  parameter int unsigned MEM = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           rate,
  input  logic                 valid_in,
  input  logic signed [SW-1:0] data_in,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 valid_out,
  output logic signed [SW-1:0] data_a,
  output logic signed [SW-1:0] data_b,
  output logic                 erase_a,
  output logic                 erase_b
`ifdef WIFI_RX_DEPUNCT_COUNT_EN
  ,
  output logic [15:0]          pair_count
`endif
);

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [1:0]           rate_q, rate_d;
  logic                 valid_q, valid_d;
  logic signed [SW-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic                 erase_a_q, erase_a_d, erase_b_q, erase_b_d;
  logic                 pop_c;
  logic [SW-1:0]        fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [1:0]           keep_c;
  logic [1:0]           period_c;

  wifi_rx_depuncturer_fifo #(.SW(SW), .AD(AD), .MEM(MEM)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (start),
    .push_i  (valid_in),
    .wdata_i (data_in),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign valid_out = valid_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign erase_a   = erase_a_q;
  assign erase_b   = erase_b_q;

  assign keep_c   = punct_keep(rate_q, phase_q);
  assign period_c = punct_period(rate_q);

  // Next-state and output logic; start overrides every state.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rate_d    = rate_q;
    valid_d   = valid_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    erase_a_d = erase_a_q;
    erase_b_d = erase_b_q;
    pop_c     = 1'b0;
    if (start) begin
      state_d = ST_RD_A;
      phase_d = 2'd0;
      valid_d = 1'b0;
      rate_d  = rate;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RD_A: begin
          if (!keep_c[1]) begin
            erase_a_d = 1'b1;
            data_a_d  = SW'(ERASE_VAL);
            state_d   = ST_RD_B;
          end else if (!fifo_empty) begin
            pop_c   = 1'b1;
            state_d = ST_CAP_A;
          end
        end
        ST_CAP_A: begin
          data_a_d  = fifo_rdata;
          erase_a_d = 1'b0;
          state_d   = ST_RD_B;
        end
        ST_RD_B: begin
          if (!keep_c[0]) begin
            erase_b_d = 1'b1;
            data_b_d  = SW'(ERASE_VAL);
            valid_d   = 1'b1;
            state_d   = ST_OUT;
          end else if (!fifo_empty) begin
            pop_c   = 1'b1;
            state_d = ST_CAP_B;
          end
        end
        ST_CAP_B: begin
          data_b_d  = fifo_rdata;
          erase_b_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            phase_d = (phase_q + 2'd1 == period_c) ? 2'd0 : phase_q + 2'd1;
            state_d = ST_RD_A;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= 2'd0;
      rate_q    <= RATE_1_2;
      valid_q   <= 1'b0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      erase_a_q <= 1'b0;
      erase_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      erase_a_q <= erase_a_d;
      erase_b_q <= erase_b_d;
    end
  end

`ifdef WIFI_RX_DEPUNCT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating handshake counter.
  always_comb begin
    cnt_d = cnt_q;
    if (start) cnt_d = 16'd0;
    else if (valid_q && out_ready && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  assign pair_count = cnt_q;
`endif

endmodule

// File: tb/tb_wifi_rx_depuncturer.sv
module tb_wifi_rx_depuncturer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rate = 2'b00;
  logic       valid_in = 1'b0;
  logic [2:0] data_in = 3'd0;
  logic       in_ready;
  logic       out_ready = 1'b0;
  logic       valid_out;
  logic [2:0] data_a, data_b;
  logic       erase_a, erase_b;
`ifdef WIFI_RX_DEPUNCT_COUNT_EN
  logic [15:0] pair_count;
`endif

  wifi_rx_depuncturer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rate      (rate),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .valid_out (valid_out),
    .data_a    (data_a),
    .data_b    (data_b),
    .erase_a   (erase_a),
    .erase_b   (erase_b)
`ifdef WIFI_RX_DEPUNCT_COUNT_EN
    ,
    .pair_count(pair_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Puncture patterns written as the transmitted pairs of one period:
  // letter = bit kept, '-' = bit punctured. Reserved rate behaves as 1/2.
  string pat [4] = '{"AB", "AB A-", "AB A- -B", "AB"};

  function automatic bit m_keep_a(int r, int ph);
    return pat[r].getc(ph * 3) != "-";
  endfunction
  function automatic bit m_keep_b(int r, int ph);
    return pat[r].getc(ph * 3 + 1) != "-";
  endfunction
  function automatic int m_period(int r);
    return (pat[r].len() + 1) / 3;
  endfunction

  // Packed pair {erase_a, a, erase_b, b}; negative value means erased.
  function automatic logic [7:0] pr(input int a, input int b);
    logic [7:0] r;
    r[7]   = (a < 0);
    r[6:4] = (a < 0) ? 3'd0 : 3'(a);
    r[3]   = (b < 0);
    r[2:0] = (b < 0) ? 3'd0 : 3'(b);
    return r;
  endfunction

  // Behavioural model state.
  int         mq[$];
  int         mrate = 0;
  int         mph = 0;
  int         mcnt = 0;
  logic [7:0] log_q[$];
  bit         prev_hold = 0;
  logic [7:0] sv_pair;

  // Compare process: every cycle, outputs sampled on the falling edge.
  always @(negedge clk) begin
    int exp_a, exp_b;
    bit ka, kb;
    if (!reset) begin
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_a", data_a, 0);
      chk("rst_data_b", data_b, 0);
      chk("rst_erase_a", erase_a, 0);
      chk("rst_erase_b", erase_b, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef WIFI_RX_DEPUNCT_COUNT_EN
      chk("rst_pair_count", pair_count, 0);
`endif
      mq.delete();
      mrate = 0; mph = 0; mcnt = 0; prev_hold = 0;
    end else begin
`ifdef WIFI_RX_DEPUNCT_COUNT_EN
      chk("pair_count", pair_count, mcnt);
`endif
      if (prev_hold) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_pair", {erase_a, data_a, erase_b, data_b}, sv_pair);
      end
      if (valid_out && out_ready) begin
        ka = m_keep_a(mrate, mph);
        kb = m_keep_b(mrate, mph);
        exp_a = 0; exp_b = 0;
        if (ka) exp_a = (mq.size() > 0) ? mq.pop_front() : -1;
        if (kb) exp_b = (mq.size() > 0) ? mq.pop_front() : -1;
        chk("pair_data_a", data_a, exp_a);
        chk("pair_erase_a", erase_a, !ka);
        chk("pair_data_b", data_b, exp_b);
        chk("pair_erase_b", erase_b, !kb);
        log_q.push_back({erase_a, data_a, erase_b, data_b});
        mph = (mph + 1) % m_period(mrate);
        if (mcnt < 65535) mcnt++;
      end
      if (start) begin
        mq.delete();
        mph = 0; mcnt = 0; mrate = rate;
      end
      if (valid_in && in_ready) mq.push_back(int'(data_in));
      prev_hold = valid_out && !out_ready && !start;
      sv_pair = {erase_a, data_a, erase_b, data_b};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r, input bit v, input int d);
    start = 1'b1; rate = 2'(r); valid_in = v; data_in = 3'(d);
    tick();
    start = 1'b0; valid_in = 1'b0;
  endtask

  task automatic push(input int d);
    valid_in = 1'b1; data_in = 3'(d);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int t = 0;
    while (log_q.size() < n && t < 500) begin tick(); t++; end
    chk("wait_pairs", (log_q.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!valid_out && t < 200) begin tick(); t++; end
    chk("wait_valid_out", valid_out, 1);
  endtask

  initial begin
    int acc, k;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Rate 1/2.
    log_q.delete(); out_ready = 1'b1;
    do_start(0, 0, 0);
    for (int i = 1; i <= 4; i++) push(i);
    wait_log(2);
    chk("r12_p0", log_q[0], pr(1, 2));
    chk("r12_p1", log_q[1], pr(3, 4));

    // Rate 2/3.
    log_q.delete();
    do_start(1, 0, 0);
    for (int i = 1; i <= 6; i++) push(i);
    wait_log(4);
    chk("r23_p0", log_q[0], pr(1, 2));
    chk("r23_p1", log_q[1], pr(3, -1));
    chk("r23_p2", log_q[2], pr(4, 5));
    chk("r23_p3", log_q[3], pr(6, -1));

    // Rate 3/4 (soft values wrap to 3 bits).
    log_q.delete();
    do_start(2, 0, 0);
    for (int i = 1; i <= 8; i++) push(i);
    wait_log(6);
    chk("r34_p0", log_q[0], pr(1, 2));
    chk("r34_p1", log_q[1], pr(3, -1));
    chk("r34_p2", log_q[2], pr(-1, 4));
    chk("r34_p3", log_q[3], pr(5, 6));
    chk("r34_p4", log_q[4], pr(7, -1));
    chk("r34_p5", log_q[5], pr(-1, 8));

    // Backpressure and FIFO fill.
    log_q.delete(); out_ready = 1'b0;
    do_start(0, 0, 0);
    push(1); push(2);
    wait_valid();
    repeat (10) tick();
    chk("bp_valid", valid_out, 1);
    chk("bp_pair", {erase_a, data_a, erase_b, data_b}, pr(1, 2));
    acc = 2; k = 3;
    for (int i = 0; i < 100 && in_ready; i++) begin
      valid_in = 1'b1; data_in = 3'(k); k++; acc++;
      tick();
    end
    chk("fill_accepted", acc, 66);
    chk("full_in_ready", in_ready, 0);
    valid_in = 1'b1; data_in = 3'(k);
    tick();
    valid_in = 1'b0;
    chk("full_in_ready_after_drop", in_ready, 0);
    out_ready = 1'b1;
    wait_log(33);
    chk("drain_last", log_q[32], pr(65, 66));
    repeat (5) tick();
    chk("drain_idle_valid", valid_out, 0);
    chk("drain_in_ready", in_ready, 1);

    // start mid-frame with phase 2 and a buffered backlog.
    log_q.delete(); out_ready = 1'b1;
    do_start(2, 0, 0);
    push(1); push(2); push(3);
    wait_log(2);
    out_ready = 1'b0;
    for (int i = 4; i <= 9; i++) push(i);
    wait_valid();
    chk("mid_pending", {erase_a, data_a, erase_b, data_b}, pr(-1, 4));
    do_start(0, 1, 7);
    chk("mid_valid_cleared", valid_out, 0);
    push(2);
    out_ready = 1'b1;
    wait_log(3);
    chk("mid_first_pair", log_q[2], pr(7, 2));

    // Reset while a pair is pending.
    log_q.delete(); out_ready = 1'b1;
    do_start(1, 0, 0);
    push(1); push(2);
    wait_log(1);
    out_ready = 1'b0;
    push(3);
    wait_valid();
    chk("pre_rst_erase_b", erase_b, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", valid_out, 0);
    chk("async_rst_pair", {erase_a, data_a, erase_b, data_b}, 0);
    chk("async_rst_in_ready", in_ready, 1);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Randomised frames, with occasional mid-frame restarts.
    for (int f = 0; f < 16; f++) begin
      do_start($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7));
      for (int c = 0; c < 150; c++) begin
        valid_in  = ($urandom_range(0, 3) != 0);
        data_in   = 3'($urandom_range(0, 7));
        out_ready = ($urandom_range(0, 9) < 7);
        start     = ($urandom_range(0, 199) == 0);
        rate      = 2'($urandom_range(0, 3));
        tick();
        start = 1'b0;
      end
      valid_in = 1'b0; out_ready = 1'b1;
      repeat (60) tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
